// File: rtl/alu_logic_pipe_pkg.sv
// Shared definitions for the pipelined logic unit: op encodings and their width.
package alu_logic_pipe_pkg;

  localparam int ALU_LOP_W = 3;

  typedef enum logic [ALU_LOP_W-1:0] {
    ALU_LOP_AND  = 3'd0,
    ALU_LOP_OR   = 3'd1,
    ALU_LOP_XOR  = 3'd2,
    ALU_LOP_NOR  = 3'd3,
    ALU_LOP_XNOR = 3'd4,
    ALU_LOP_ANDN = 3'd5,
    ALU_LOP_PASS = 3'd6,
    ALU_LOP_NOT  = 3'd7
  } alu_lop_e;

endpackage

// File: rtl/alu_logic_pipe_if.sv
// Issue-side and writeback-side bundles of the logic unit.
// Handshake: a side transfers on a rising edge where valid && ready; valid must not
// depend on ready, and a bundle with valid high holds steady until it transfers.
interface alu_logic_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import alu_logic_pipe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_LOP_W-1:0] in_op;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic                 out_zero;
  logic                 out_parity;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_parity, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_parity, out_tag
  );

endinterface

// File: rtl/alu_pipe_reg.sv
// One elastic pipeline stage: loads whenever empty or when downstream takes its bundle.
module alu_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign up_ready = !valid_q || dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      // Data only moves with a real bundle; a bubble leaves the old value in place.
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage elastic bitwise logic unit with zero/parity flags and a passthrough tag.
module alu_logic_pipe
  import alu_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  alu_logic_pipe_if.slave bus
);

  localparam int S1_W = ALU_LOP_W + 2 * WIDTH + TAG_W;
  localparam int S2_W = WIDTH + 2 + TAG_W;

  logic [S1_W-1:0]      s1_data_d;
  logic [S1_W-1:0]      s1_data_q;
  logic                 s1_valid;
  logic                 s2_load;
  logic [ALU_LOP_W-1:0] s1_op;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [TAG_W-1:0]     s1_tag;

  logic [WIDTH-1:0]     result_d;
  logic                 nzero_d;
  logic                 parity_d;
  logic [S2_W-1:0]      s2_data_d;
  logic [S2_W-1:0]      s2_data_q;
  logic [WIDTH-1:0]     result_q;
  logic                 nzero_q;
  logic                 parity_q;
  logic [TAG_W-1:0]     tag_q;

  assign s1_data_d = {bus.in_op, bus.in_a, bus.in_b, bus.in_tag};

  alu_pipe_reg #(.W(S1_W)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (bus.in_valid),
    .up_ready (bus.in_ready),
    .up_data  (s1_data_d),
    .dn_valid (s1_valid),
    .dn_ready (s2_load),
    .dn_data  (s1_data_q)
  );

  assign {s1_op, s1_a, s1_b, s1_tag} = s1_data_q;

  always_comb begin
    result_d = '0;
    case (alu_lop_e'(s1_op))
      ALU_LOP_AND:  result_d = s1_a & s1_b;
      ALU_LOP_OR:   result_d = s1_a | s1_b;
      ALU_LOP_XOR:  result_d = s1_a ^ s1_b;
      ALU_LOP_NOR:  result_d = ~(s1_a | s1_b);
      ALU_LOP_XNOR: result_d = ~(s1_a ^ s1_b);
      ALU_LOP_ANDN: result_d = s1_a & ~s1_b;
      ALU_LOP_PASS: result_d = s1_a;
      ALU_LOP_NOT:  result_d = ~s1_a;
    endcase
    nzero_d  = |result_d;
    parity_d = ^result_d;
  end

  // Zero is stored inverted so the all-zero reset image reads as "result is zero".
  assign s2_data_d = {result_d, nzero_d, parity_d, s1_tag};

  alu_pipe_reg #(.W(S2_W)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s1_valid),
    .up_ready (s2_load),
    .up_data  (s2_data_d),
    .dn_valid (bus.out_valid),
    .dn_ready (bus.out_ready),
    .dn_data  (s2_data_q)
  );

  assign {result_q, nzero_q, parity_q, tag_q} = s2_data_q;

  assign bus.out_result = result_q;
  assign bus.out_zero   = !nzero_q;
  assign bus.out_parity = parity_q;
  assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Directed and random checks for alu_logic_pipe at WIDTH=32/TAG_W=5 and WIDTH=1/TAG_W=1.
module tb_alu_logic_pipe;
  import alu_logic_pipe_pkg::*;

  logic clk;
  logic rst_n;

  alu_logic_pipe_if #(.WIDTH(32), .TAG_W(5)) bus0 ();
  alu_logic_pipe_if #(.WIDTH(1),  .TAG_W(1)) bus1 ();

  alu_logic_pipe #(.WIDTH(32), .TAG_W(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  alu_logic_pipe #(.WIDTH(1),  .TAG_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        zero;
    logic        par;
  } vec_t;

  vec_t vecs[10];

  // Reference for the 1-bit build, written independently of the RTL.
  function automatic logic lop1(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return !(a | b);
      3'd4: return !(a ^ b);
      3'd5: return a & !b;
      3'd6: return a;
      default: return !a;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
    bus0.in_valid = v;
    bus0.in_op    = op;
    bus0.in_a     = a;
    bus0.in_b     = b;
    bus0.in_tag   = tag;
  endtask

  logic [36:0] exp_q[$];
  logic [3:0]  sb_q[$];

  initial begin
    int next_tag;
    int n_rx;
    int cnt;
    logic saw_low;
    logic held;
    logic r1;

    vecs[0] = '{ALU_LOP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1,  32'h00F0_1234, 1'b0, 1'b1};
    vecs[1] = '{ALU_LOP_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 5'd2,  32'hFFF0_FFFF, 1'b0, 1'b0};
    vecs[2] = '{ALU_LOP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3,  32'hFF00_EDCB, 1'b0, 1'b1};
    vecs[3] = '{ALU_LOP_NOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4,  32'h000F_0000, 1'b0, 1'b0};
    vecs[4] = '{ALU_LOP_XNOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5,  32'h00FF_1234, 1'b0, 1'b1};
    vecs[5] = '{ALU_LOP_ANDN, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd6,  32'hF000_0000, 1'b0, 1'b0};
    vecs[6] = '{ALU_LOP_PASS, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7,  32'hF0F0_1234, 1'b0, 1'b1};
    vecs[7] = '{ALU_LOP_NOT,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd31, 32'h0F0F_EDCB, 1'b0, 1'b1};
    vecs[8] = '{ALU_LOP_XOR,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9,  32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{ALU_LOP_OR,   32'h0000_0001, 32'h0000_0000, 5'd10, 32'h0000_0001, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive0(1'b0, 3'd0, '0, '0, '0);
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_op     = 3'd0;
    bus1.in_a      = 1'b0;
    bus1.in_b      = 1'b0;
    bus1.in_tag    = 1'b0;
    bus1.out_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_out_valid",  bus0.out_valid,  0);
    check("rst_out_result", bus0.out_result, 0);
    check("rst_out_zero",   bus0.out_zero,   1);
    check("rst_out_parity", bus0.out_parity, 0);
    check("rst_out_tag",    bus0.out_tag,    0);
    check("rst_in_ready",   bus0.in_ready,   1);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table: every op plus flag corners, one bundle at a time ----
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      #1 check($sformatf("vec%0d_in_ready", i), bus0.in_ready, 1);
      @(negedge clk);
      drive0(1'b0, 3'd0, '0, '0, '0);
      // After the accepting edge only S1 holds the bundle.
      check($sformatf("vec%0d_early_valid", i), bus0.out_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i),  bus0.out_valid,  1);
      check($sformatf("vec%0d_result", i),     bus0.out_result, vecs[i].res);
      check($sformatf("vec%0d_zero", i),       bus0.out_zero,   vecs[i].zero);
      check($sformatf("vec%0d_parity", i),     bus0.out_parity, vecs[i].par);
      check($sformatf("vec%0d_tag", i),        bus0.out_tag,    vecs[i].tag);
    end
    @(negedge clk);

    // ---- backpressure: tags 1..6, out_ready low on cycles 3..7 ----
    next_tag = 1;
    n_rx     = 0;
    cnt      = 0;
    saw_low  = 1'b0;
    for (int c = 1; c <= 40 && n_rx < 6; c++) begin
      bus0.out_ready = !(c >= 3 && c <= 7);
      if (next_tag <= 6)
        drive0(1'b1, ALU_LOP_XOR, 32'(32'h1111_1111 * next_tag), 32'h0000_FFFF, next_tag[4:0]);
      else
        drive0(1'b0, 3'd0, '0, '0, '0);
      #1;
      check("bp_in_ready", bus0.in_ready, !(cnt == 2 && !bus0.out_ready));
      if (!bus0.in_ready) saw_low = 1'b1;
      if (bus0.out_valid) begin
        if (exp_q.size() == 0) check("bp_spurious_out", 1, 0);
        else begin
          check("bp_out", {bus0.out_tag, bus0.out_result}, exp_q[0]);
          if (bus0.out_ready) begin
            void'(exp_q.pop_front());
            n_rx++;
            cnt--;
          end
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        exp_q.push_back({next_tag[4:0], 32'(32'h1111_1111 * next_tag) ^ 32'h0000_FFFF});
        next_tag++;
        cnt++;
      end
      @(negedge clk);
    end
    check("bp_received", n_rx, 6);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_in_ready_dropped", saw_low, 1);

    // ---- reset mid-stream with two bundles in flight ----
    bus0.out_ready = 1'b1;
    drive0(1'b1, ALU_LOP_OR, 32'h0000_00A0, 32'h0000_0005, 5'd20);
    @(negedge clk);
    drive0(1'b1, ALU_LOP_OR, 32'h0000_00B0, 32'h0000_0006, 5'd21);
    @(negedge clk);
    drive0(1'b0, 3'd0, '0, '0, '0);
    check("mid_out_valid_before", bus0.out_valid, 1);
    check("mid_result_before",    bus0.out_result, 32'h0000_00A5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid_async", bus0.out_valid,  0);
    check("mid_result_async",    bus0.out_result, 0);
    check("mid_zero_async",      bus0.out_zero,   1);
    check("mid_in_ready_async",  bus0.in_ready,   1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid_nothing_emerges", bus0.out_valid, 0);
    end

    // ---- 1-bit build: directed NOT, then random traffic ----
    bus1.in_valid = 1'b1;
    bus1.in_op    = ALU_LOP_NOT;
    bus1.in_a     = 1'b0;
    bus1.in_b     = 1'b0;
    bus1.in_tag   = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("w1_out_valid", bus1.out_valid,  1);
    check("w1_not_result", bus1.out_result, 1);
    check("w1_not_parity", bus1.out_parity, 1);
    check("w1_not_zero",   bus1.out_zero,   0);
    check("w1_not_tag",    bus1.out_tag,    1);
    @(negedge clk);

    held = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!held) begin
        bus1.in_valid = 1'($urandom_range(0, 1));
        bus1.in_op    = 3'($urandom_range(0, 7));
        bus1.in_a     = 1'($urandom_range(0, 1));
        bus1.in_b     = 1'($urandom_range(0, 1));
        bus1.in_tag   = 1'($urandom_range(0, 1));
      end
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus1.out_valid && bus1.out_ready) begin
        if (sb_q.size() == 0) check("w1_spurious_out", 1, 0);
        else check("w1_scoreboard",
                   {bus1.out_result, bus1.out_zero, bus1.out_parity, bus1.out_tag},
                   sb_q.pop_front());
      end
      if (bus1.in_valid && bus1.in_ready) begin
        r1 = lop1(bus1.in_op, bus1.in_a, bus1.in_b);
        sb_q.push_back({r1, !r1, r1, bus1.in_tag});
      end
      held = bus1.in_valid && !bus1.in_ready;
      @(negedge clk);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus1.out_valid) begin
        if (sb_q.size() == 0) check("w1_spurious_drain", 1, 0);
        else check("w1_drain", {bus1.out_result, bus1.out_zero, bus1.out_parity, bus1.out_tag},
                   sb_q.pop_front());
      end
      @(negedge clk);
    end
    check("w1_sb_empty", sb_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
